// File: rtl/sram_bus_pkg.sv
// Shared widths, state encoding and default timing for the SRAM bus sequencer.
package sram_bus_pkg;

    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 8;
    localparam int ADDR_LO_W = 8;
    localparam int ADDR_HI_W = ADDR_W - ADDR_LO_W;
    localparam int CNT_W     = 8;

    // Default wait-state counts.
    localparam int LE_CYC_DEF = 1;
    localparam int WE_CYC_DEF = 2;
    localparam int OE_CYC_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        HOLD,
        WPULSE,
        WREC,
        RPULSE,
        DONE
    } state_t;

    // A state lasting n cycles loads n-1 and leaves when the counter reads 0.
    function automatic logic [CNT_W-1:0] cyc_to_load(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// 8-bit loadable down-counter with a zero flag; holds at zero.
module sram_wait_cnt
    import sram_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load on state entry, otherwise count down towards zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_bus_sequencer.sv
// Sequences a 62256 SRAM behind a 74LS373 low-address latch.
// Every output is a register whose next value is decoded from the next state,
// so outputs change on the same edge as the state they belong to.
module sram_bus_sequencer
    import sram_bus_pkg::*;
#(
    parameter int LE_CYC = LE_CYC_DEF,
    parameter int WE_CYC = WE_CYC_DEF,
    parameter int OE_CYC = OE_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [14:0] addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic [7:0]  bus_ad,
    output logic        bus_drive,
    input  logic [7:0]  bus_ad_in,
    output logic        le,
    output logic        latch_oe_n,
    output logic [6:0]  addr_hi,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    if (LE_CYC < 1 || LE_CYC > 255) begin : g_bad_le
        $error("LE_CYC must be in 1..255");
    end
    if (WE_CYC < 1 || WE_CYC > 255) begin : g_bad_we
        $error("WE_CYC must be in 1..255");
    end
    if (OE_CYC < 1 || OE_CYC > 255) begin : g_bad_oe
        $error("OE_CYC must be in 1..255");
    end

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                wr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_wdata;

    logic                cnt_load;
    logic [CNT_W-1:0]    cnt_val;
    logic                cnt_zero;

    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   bus_ad_q, bus_ad_d;
    logic                bus_drive_q, bus_drive_d;
    logic                le_q, le_d;
    logic                latch_oe_n_q, latch_oe_n_d;
    logic [ADDR_HI_W-1:0] addr_hi_q, addr_hi_d;
    logic                sram_ce_n_q, sram_ce_n_d;
    logic                sram_oe_n_q, sram_oe_n_d;
    logic                sram_we_n_q, sram_we_n_d;

    sram_wait_cnt u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    // The request is captured on the IDLE->LATCH edge, so LATCH outputs for
    // that edge must come straight from the host inputs.
    assign cur_addr  = (state_q == IDLE) ? addr  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? wdata : wdata_q;

    // Next-state, wait-counter control and next-output decode.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d  = LATCH;
                    cnt_load = 1'b1;
                    cnt_val  = cyc_to_load(LE_CYC);
                end
            end
            LATCH: begin
                if (cnt_zero) begin
                    state_d  = HOLD;
                    cnt_load = 1'b1;
                end
            end
            HOLD: begin
                cnt_load = 1'b1;
                if (wr_q) begin
                    state_d = WPULSE;
                    cnt_val = cyc_to_load(WE_CYC);
                end else begin
                    state_d = RPULSE;
                    cnt_val = cyc_to_load(OE_CYC);
                end
            end
            WPULSE: begin
                if (cnt_zero) begin
                    state_d  = WREC;
                    cnt_load = 1'b1;
                end
            end
            WREC: begin
                state_d  = DONE;
                cnt_load = 1'b1;
            end
            RPULSE: begin
                if (cnt_zero) begin
                    state_d  = DONE;
                    cnt_load = 1'b1;
                    rdata_d  = bus_ad_in;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ack_d        = 1'b0;
        busy_d       = (state_d != IDLE);
        bus_ad_d     = bus_ad_q;
        bus_drive_d  = 1'b0;
        le_d         = 1'b0;
        latch_oe_n_d = 1'b1;
        addr_hi_d    = addr_hi_q;
        sram_ce_n_d  = 1'b1;
        sram_oe_n_d  = 1'b1;
        sram_we_n_d  = 1'b1;

        case (state_d)
            LATCH: begin
                bus_drive_d = 1'b1;
                bus_ad_d    = cur_addr[ADDR_LO_W-1:0];
                le_d        = 1'b1;
                addr_hi_d   = cur_addr[ADDR_W-1:ADDR_LO_W];
            end
            HOLD: begin
                latch_oe_n_d = 1'b0;
                sram_ce_n_d  = 1'b0;
                // Reads release the bus here to give the SRAM a turnaround cycle.
                if (wr_q) begin
                    bus_drive_d = 1'b1;
                    bus_ad_d    = cur_wdata;
                end
            end
            WPULSE: begin
                latch_oe_n_d = 1'b0;
                sram_ce_n_d  = 1'b0;
                sram_we_n_d  = 1'b0;
                bus_drive_d  = 1'b1;
                bus_ad_d     = cur_wdata;
            end
            WREC: begin
                // Data stays on the bus one cycle past the WE rising edge.
                latch_oe_n_d = 1'b0;
                sram_ce_n_d  = 1'b0;
                bus_drive_d  = 1'b1;
                bus_ad_d     = cur_wdata;
            end
            RPULSE: begin
                latch_oe_n_d = 1'b0;
                sram_ce_n_d  = 1'b0;
                sram_oe_n_d  = 1'b0;
            end
            DONE: begin
                ack_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            ack_q        <= 1'b0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            bus_ad_q     <= '0;
            bus_drive_q  <= 1'b0;
            le_q         <= 1'b0;
            latch_oe_n_q <= 1'b1;
            addr_hi_q    <= '0;
            sram_ce_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
            sram_we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                addr_q  <= addr;
                wr_q    <= wr;
                wdata_q <= wdata;
            end
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
            bus_ad_q     <= bus_ad_d;
            bus_drive_q  <= bus_drive_d;
            le_q         <= le_d;
            latch_oe_n_q <= latch_oe_n_d;
            addr_hi_q    <= addr_hi_d;
            sram_ce_n_q  <= sram_ce_n_d;
            sram_oe_n_q  <= sram_oe_n_d;
            sram_we_n_q  <= sram_we_n_d;
        end
    end

    assign ack        = ack_q;
    assign rdata      = rdata_q;
    assign busy       = busy_q;
    assign bus_ad     = bus_ad_q;
    assign bus_drive  = bus_drive_q;
    assign le         = le_q;
    assign latch_oe_n = latch_oe_n_q;
    assign addr_hi    = addr_hi_q;
    assign sram_ce_n  = sram_ce_n_q;
    assign sram_oe_n  = sram_oe_n_q;
    assign sram_we_n  = sram_we_n_q;

    // Bus-contention and strobe-ordering invariants.
    a_no_drive_during_oe: assert property (@(posedge clk) disable iff (rst)
        !(bus_drive_q && !sram_oe_n_q));
    a_we_oe_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(!sram_we_n_q && !sram_oe_n_q));
    a_le_low_when_ce: assert property (@(posedge clk) disable iff (rst)
        (sram_ce_n_q || !le_q));
    a_strobes_need_ce: assert property (@(posedge clk) disable iff (rst)
        ((sram_we_n_q && sram_oe_n_q) || !sram_ce_n_q));

endmodule

// File: tb/tb_sram_bus_sequencer.sv
// Scoreboard bench: instance 0 uses default timing, instance 1 uses
// LE_CYC=3/WE_CYC=4/OE_CYC=1. Each instance has a behavioural latch + SRAM.
// Ack timing: with req sampled at edge k, an access whose ack is "high in
// cycle k+L" shows ack after edge k+L-1 (cycle k+L ends at edge k+L).
module tb_sram_bus_sequencer;

    typedef struct {
        int         inst;
        bit         w;
        logic [14:0] a;
        logic [7:0] d;
        int         ack_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req [2];
    logic       wr [2];
    logic [14:0] addr [2];
    logic [7:0] wdata [2];
    logic       ack [2];
    logic [7:0] rdata [2];
    logic       busy [2];
    logic [7:0] bus_ad [2];
    logic       bus_drive [2];
    logic [7:0] bus_ad_in [2];
    logic       le [2];
    logic       latch_oe_n [2];
    logic [6:0] addr_hi [2];
    logic       sram_ce_n [2];
    logic       sram_oe_n [2];
    logic       sram_we_n [2];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int le_of(int inst); return (inst == 0) ? 1 : 3; endfunction
    function automatic int we_of(int inst); return (inst == 0) ? 2 : 4; endfunction
    function automatic int oe_of(int inst); return (inst == 0) ? 2 : 1; endfunction
    function automatic int lat_of(int inst, bit w);
        return w ? (le_of(inst) + we_of(inst) + 3) : (le_of(inst) + oe_of(inst) + 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic [7:0] mem [32768];
        logic [7:0] lat_lo = 8'h00;
        logic       prev_we = 1'b1;

        initial begin
            for (int j = 0; j < 32768; j++) mem[j] = 8'h00;
        end

        sram_bus_sequencer #(
            .LE_CYC ((gi == 0) ? 1 : 3),
            .WE_CYC ((gi == 0) ? 2 : 4),
            .OE_CYC ((gi == 0) ? 2 : 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req        (req[gi]),
            .wr         (wr[gi]),
            .addr       (addr[gi]),
            .wdata      (wdata[gi]),
            .ack        (ack[gi]),
            .rdata      (rdata[gi]),
            .busy       (busy[gi]),
            .bus_ad     (bus_ad[gi]),
            .bus_drive  (bus_drive[gi]),
            .bus_ad_in  (bus_ad_in[gi]),
            .le         (le[gi]),
            .latch_oe_n (latch_oe_n[gi]),
            .addr_hi    (addr_hi[gi]),
            .sram_ce_n  (sram_ce_n[gi]),
            .sram_oe_n  (sram_oe_n[gi]),
            .sram_we_n  (sram_we_n[gi])
        );

        assign bus_ad_in[gi] = (!sram_ce_n[gi] && !sram_oe_n[gi]) ? mem[{addr_hi[gi], lat_lo}] : 8'hEE;

        // Transparent latch and write on the WE rising edge with CE still low.
        always @(negedge clk) begin
            if (le[gi]) lat_lo <= bus_ad[gi];
            prev_we <= sram_we_n[gi];
            if (!prev_we && sram_we_n[gi] && !sram_ce_n[gi])
                mem[{addr_hi[gi], lat_lo}] <= bus_ad[gi];
        end
    end

    // Monitor: measures strobe widths and checks each ack against the scoreboard.
    int         le_cnt [2], we_cnt [2], oe_cnt [2], dce_cnt [2];
    logic [7:0] le_ad [2], we_ad [2], last_rd [2];
    logic [6:0] le_hi [2];

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                le_cnt[i] = 0; we_cnt[i] = 0; oe_cnt[i] = 0; dce_cnt[i] = 0;
                last_rd[i] = 8'h00;
            end else begin
                if (le[i]) begin le_cnt[i]++; le_ad[i] = bus_ad[i]; le_hi[i] = addr_hi[i]; end
                if (!sram_we_n[i]) begin we_cnt[i]++; we_ad[i] = bus_ad[i]; end
                if (!sram_oe_n[i]) oe_cnt[i]++;
                if (!sram_ce_n[i] && bus_drive[i]) dce_cnt[i]++;
                if (ack[i]) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ack", 32'(i), 32'hFFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("ack_inst", 32'(i), 32'(e.inst));
                        chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
                        chk("le_width", 32'(le_cnt[i]), 32'(le_of(i)));
                        chk("le_bus_ad", 32'(le_ad[i]), 32'(e.a[7:0]));
                        chk("le_addr_hi", 32'(le_hi[i]), 32'(e.a[14:8]));
                        if (e.w) begin
                            chk("we_width", 32'(we_cnt[i]), 32'(we_of(i)));
                            chk("we_bus_ad", 32'(we_ad[i]), 32'(e.d));
                            chk("wr_oe_width", 32'(oe_cnt[i]), 32'd0);
                            chk("wr_drive_cycles", 32'(dce_cnt[i]), 32'(we_of(i) + 2));
                            chk("wr_rdata_kept", 32'(rdata[i]), 32'(last_rd[i]));
                        end else begin
                            chk("oe_width", 32'(oe_cnt[i]), 32'(oe_of(i)));
                            chk("rd_we_width", 32'(we_cnt[i]), 32'd0);
                            chk("rd_drive_cycles", 32'(dce_cnt[i]), 32'd0);
                            chk("rd_rdata", 32'(rdata[i]), 32'(e.d));
                            last_rd[i] = rdata[i];
                        end
                    end
                    le_cnt[i] = 0; we_cnt[i] = 0; oe_cnt[i] = 0; dce_cnt[i] = 0;
                end
            end
        end
    end

    // Issue one access; expected ack cycle and data go to the scoreboard.
    task automatic do_access(input int inst, input bit w, input logic [14:0] a,
                             input logic [7:0] d, input logic [7:0] erd, input bit hold);
        int   t;
        exp_t e;
        @(negedge clk);
        t = 0;
        while (busy[inst] && t < 100) begin @(negedge clk); t++; end
        if (busy[inst]) chk("idle_wait_timeout", 32'(t), 32'd0);
        req[inst] = 1'b1; wr[inst] = w; addr[inst] = a; wdata[inst] = d;
        @(posedge clk);
        #1;
        e.inst = inst; e.w = w; e.a = a; e.d = w ? d : erd;
        e.ack_cyc = cyc + lat_of(inst, w) - 1;
        sb.push_back(e);
        @(negedge clk);
        if (hold) begin
            t = 0;
            while (!ack[inst] && t < 100) begin @(negedge clk); t++; end
        end
        req[inst] = 1'b0;
        t = 0;
        while (!ack[inst] && t < 100) begin @(negedge clk); t++; end
        if (!ack[inst]) chk("ack_timeout", 32'(t), 32'd0);
        $display("access inst=%0d %s addr=%h data=%h ack_cycle=%0d", inst, w ? "WR" : "RD",
                 a, w ? d : erd, e.ack_cyc);
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_rdata", 32'(rdata[i]), 32'h00);
            chk("rst_bus_ad", 32'(bus_ad[i]), 32'h00);
            chk("rst_addr_hi", 32'(addr_hi[i]), 32'h00);
            chk("rst_latch_oe_n", 32'(latch_oe_n[i]), 32'd1);
        end
        @(negedge clk);
        rst = 1'b0;

        // Idle with no requests.
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!sram_ce_n[0] || !sram_oe_n[0] || !sram_we_n[0] || busy[0] || ack[0] ||
                bus_drive[0] || le[0]) bad++;
        end
        chk("idle_bad_cycles", 32'(bad), 32'd0);
        chk("idle_ce_n", 32'(sram_ce_n[0]), 32'd1);
        chk("idle_we_n", 32'(sram_we_n[0]), 32'd1);
        chk("idle_oe_n", 32'(sram_oe_n[0]), 32'd1);
        chk("idle_busy", 32'(busy[0]), 32'd0);

        // Single write then readback.
        do_access(0, 1'b1, 15'h0005, 8'hA5, 8'h00, 1'b0);
        chk("sram_0005", 32'(g_inst[0].mem[15'h0005]), 32'hA5);
        do_access(0, 1'b0, 15'h0005, 8'h00, 8'hA5, 1'b0);

        // Legacy sweep over both pages.
        for (int i = 0; i < 8; i++)
            do_access(0, 1'b1, 15'(i), 8'(7 - i), 8'h00, 1'b0);
        for (int i = 0; i < 8; i++)
            do_access(0, 1'b1, 15'h7F00 | 15'(i), 8'(7 - i), 8'h00, 1'b0);
        for (int i = 0; i < 8; i++)
            do_access(0, 1'b0, 15'(i), 8'h00, 8'(7 - i), 1'b0);
        for (int i = 0; i < 8; i++)
            do_access(0, 1'b0, 15'h7F00 | 15'(i), 8'h00, 8'(7 - i), 1'b0);
        // Page independence: touching 0x7F03 leaves 0x0003 alone.
        do_access(0, 1'b1, 15'h7F03, 8'h3C, 8'h00, 1'b0);
        do_access(0, 1'b0, 15'h0003, 8'h00, 8'h04, 1'b0);
        do_access(0, 1'b0, 15'h7F03, 8'h00, 8'h3C, 1'b0);

        // Non-default timing instance, including the top address.
        do_access(1, 1'b1, 15'h1234, 8'h5A, 8'h00, 1'b0);
        do_access(1, 1'b0, 15'h1234, 8'h00, 8'h5A, 1'b0);
        do_access(1, 1'b1, 15'h7FFF, 8'hC3, 8'h00, 1'b0);
        do_access(1, 1'b0, 15'h7FFF, 8'h00, 8'hC3, 1'b0);

        // Reset during the first WPULSE cycle.
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 15'h0100; wdata[0] = 8'hFF;
        @(posedge clk);          // accepted -> LATCH
        @(negedge clk);
        req[0] = 1'b0;
        @(posedge clk);          // HOLD
        @(posedge clk);          // WPULSE cycle 1
        #1;
        chk("pre_rst_we_low", 32'(sram_we_n[0]), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_we_n", 32'(sram_we_n[0]), 32'd1);
        chk("rst_ce_n", 32'(sram_ce_n[0]), 32'd1);
        chk("rst_bus_drive", 32'(bus_drive[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        $display("reset during WPULSE applied");
        do_access(0, 1'b1, 15'h0100, 8'h11, 8'h00, 1'b0);
        do_access(0, 1'b0, 15'h0100, 8'h00, 8'h11, 1'b0);

        // Host holds req until ack: exactly one ack per accepted request.
        do_access(0, 1'b1, 15'h0200, 8'h77, 8'h00, 1'b1);
        repeat (8) @(negedge clk);
        do_access(0, 1'b0, 15'h0200, 8'h00, 8'h77, 1'b1);
        repeat (8) @(negedge clk);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sram_bus_sequencer.md
Name: sram_bus_sequencer

Overview:
- Synchronous controller that sequences the 62256 32Kx8 SRAM and its 74LS373 low-address latch, replacing the bit-banged port sequence.
- Takes single-beat read/write requests from a host and generates the multiplexed address/data bus, latch enable, high-address lines and SRAM strobes with programmable wait states.
- Returns read data and a one-cycle acknowledge.

Parameters:
- LE_CYC, default 1: cycles the latch enable is held high with the low address on the bus (1..255).
- WE_CYC, default 2: cycles sram_we_n is held low (1..255).
- OE_CYC, default 2: cycles sram_oe_n is held low before read data is captured (1..255).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  host request; sampled only in IDLE.
- wr  in  1  1 = write, 0 = read; captured with req.
- addr  in  15  SRAM byte address; captured with req.
- wdata  in  8  write data; captured with req.
- ack  out  1  one-cycle pulse: access complete.
- rdata  out  8  read data; valid from ack until the next read's ack.
- busy  out  1  high in every state except IDLE.
- bus_ad  out  8  multiplexed low address / write data.
- bus_drive  out  1  tri-state enable for bus_ad.
- bus_ad_in  in  8  SRAM data-out sampled during reads.
- le  out  1  74LS373 latch enable, active high.
- latch_oe_n  out  1  74LS373 output enable, active low.
- addr_hi  out  7  SRAM address bits 14:8.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active low.

Behaviour:
- Reset (async, immediate): state IDLE; ack=0, busy=0, rdata=0, bus_ad=0, bus_drive=0, le=0, latch_oe_n=1, addr_hi=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1. Reset mid-access abandons the cycle and deasserts all strobes at once. No ack is issued.
- All outputs are registered. Single wait counter, 8 bits, loaded on state entry with N-1 and decremented; exit occurs when it reaches 0.
- IDLE: if req=1 at an edge, capture addr/wr/wdata and go to LATCH. Otherwise stay.
- LATCH (LE_CYC cycles): bus_drive=1, bus_ad=addr[7:0], le=1, addr_hi=addr[14:8].
- HOLD (1 cycle): le=0, latch_oe_n=0, sram_ce_n=0.
  - Write: bus_ad=wdata, bus_drive=1.
  - Read: bus_drive=0, giving a turnaround cycle.
  - Next state is WPULSE for a write, RPULSE for a read.
- WPULSE (WE_CYC cycles): sram_we_n=0, wdata driven. Then go to WREC.
- WREC (1 cycle): sram_we_n=1, data still driven for hold time. Then go to DONE.
- RPULSE (OE_CYC cycles): sram_oe_n=0, bus_drive=0. On the last cycle, rdata<=bus_ad_in. Then go to DONE.
- DONE (1 cycle):
  - ack=1, sram_ce_n=1, sram_oe_n=1, latch_oe_n=1, bus_drive=0. Go to IDLE.
  - rdata is unchanged on write acks.
- Latency, with req sampled at edge k:
  - Write ack is high in cycle k+LE_CYC+WE_CYC+3 (k+6 with defaults).
  - Read ack is high in cycle k+LE_CYC+OE_CYC+2 (k+5 with defaults).
- Back-to-back: the earliest next acceptance is the edge after DONE, so there is one IDLE cycle minimum between accesses. req during busy is ignored (no queue). The host holds req until ack, or pulses it in IDLE.
- Invariants, checked by assertions:
  - Never bus_drive=1 while sram_oe_n=0.
  - Never sram_we_n=0 and sram_oe_n=0 together.
  - le=0 whenever sram_ce_n=0.
  - sram_we_n/sram_oe_n low only while sram_ce_n=0.
- Address wrap: none internal. addr is used verbatim; 0x7FFF is a legal address.
- Parameters of 0 or >255: elaboration error.

Decomposition:
- Package sram_bus_pkg holds:
  - ADDR_W=15, DATA_W=8, ADDR_LO_W=8.
  - State enum {IDLE, LATCH, HOLD, WPULSE, WREC, RPULSE, DONE}.
  - Default timing constants.
- One sub-module, sram_wait_cnt: 8-bit loadable down-counter with a zero flag, instanced once.

Test Plan:
- Reset then idle: no req for 10 cycles -> all strobes inactive, busy=0, ack=0, bus_drive=0.
- Single write: req, wr=1, addr=0x0005, wdata=0xA5 -> le high 1 cycle with bus_ad=0x05, addr_hi=0x00; sram_we_n low 2 cycles with bus_ad=0xA5; ack at k+6; behavioural SRAM holds 0xA5 at 0x0005.
- Readback: read addr=0x0005 -> sram_oe_n low 2 cycles, bus_drive=0 from HOLD; ack at k+5 with rdata=0xA5.
- Sweep replicating the legacy pattern: write 7-i to addresses i (i=0..7) with addr_hi=0x00, then the same with addr[14:8]=0x7F; read all 16 back -> each correct and the two pages independent (0x7F07 reads 0x00).
- Timing parameters LE_CYC=3, WE_CYC=4, OE_CYC=1: write ack at k+10, read ack at k+6; strobe widths match exactly.
- rst asserted during WPULSE cycle 1 -> sram_we_n, sram_ce_n high and bus_drive=0 immediately; no ack; next request completes normally. Also req held during busy -> exactly one ack per accepted request.
